// File: rtl/bus_slave_port.sv
// bus_slave_port
//   Slave-side endpoint of the arbiter's serial bus. Each transfer is one
//   address phase (ADDR_WIDTH bits on s_address, MSB first), then either a
//   write-data phase (DATA_WIDTH bits on s_data, MSB first) followed by a
//   one-cycle memory write, or a one-cycle memory fetch followed by DATA_WIDTH
//   read-data bits serialised on s_data_out, MSB first.
//
// Ports
//   clk          bus clock, rising edge
//   reset        asynchronous, active-high; FSM back to IDLE, outputs to idle values
//   s_address    serial address bit, MSB first
//   s_data       serial write-data bit, MSB first
//   s_valid      transfer framing, high for the whole transfer; low aborts
//   s_write_en   1 = write, 0 = read; sampled only with the first address bit
//   s_data_out   serial read data, MSB first (registered)
//   s_ready      high while idle and able to accept a transfer (registered)
//   s_valid_out  high while s_data_out carries read-data bits (registered)
module bus_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic s_address,
  input  logic s_data,
  input  logic s_valid,
  input  logic s_write_en,
  output logic s_data_out,
  output logic s_ready,
  output logic s_valid_out
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RMEM, RDATA} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_sr, addr_sr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_sr, wdata_sr_nxt;
  logic [DATA_WIDTH-1:0]   rshift, rshift_nxt;
  logic                    we, we_nxt;
  logic                    ready_nxt, valid_out_nxt, data_out_nxt;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rd;

  logic [DATA_WIDTH-1:0]   mem [0:2**ADDR_WIDTH-1];

  assign mem_rd = mem[addr_sr];

  // Memory contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_sr] <= wdata_sr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      addr_sr     <= '0;
      wdata_sr    <= '0;
      rshift      <= '0;
      we          <= 1'b0;
      s_ready     <= 1'b1;
      s_valid_out <= 1'b0;
      s_data_out  <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      addr_sr     <= addr_sr_nxt;
      wdata_sr    <= wdata_sr_nxt;
      rshift      <= rshift_nxt;
      we          <= we_nxt;
      s_ready     <= ready_nxt;
      s_valid_out <= valid_out_nxt;
      s_data_out  <= data_out_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    addr_sr_nxt   = addr_sr;
    wdata_sr_nxt  = wdata_sr;
    rshift_nxt    = rshift;
    we_nxt        = we;
    ready_nxt     = s_ready;
    valid_out_nxt = s_valid_out;
    data_out_nxt  = s_data_out;
    mem_we        = 1'b0;

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (s_valid) begin
          // Left shift: the first bit lands in the MSB after ADDR_WIDTH shifts.
          we_nxt      = s_write_en;
          addr_sr_nxt = {addr_sr[ADDR_WIDTH-2:0], s_address};
          bit_cnt_nxt = CNT_W'(1);
          ready_nxt   = 1'b0;
          state_nxt   = ADDR;
        end
      end

      ADDR: begin
        if (!s_valid) begin
          bit_cnt_nxt = '0;
          ready_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else begin
          addr_sr_nxt = {addr_sr[ADDR_WIDTH-2:0], s_address};
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = we ? WDATA : RMEM;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      WDATA: begin
        if (!s_valid) begin
          bit_cnt_nxt = '0;
          ready_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wdata_sr_nxt = {wdata_sr[DATA_WIDTH-2:0], s_data};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = WRITE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      WRITE: begin
        mem_we    = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end

      RMEM: begin
        rshift_nxt    = mem_rd;
        valid_out_nxt = 1'b1;
        data_out_nxt  = mem_rd[DATA_WIDTH-1];
        bit_cnt_nxt   = '0;
        state_nxt     = RDATA;
      end

      RDATA: begin
        if (!s_valid || bit_cnt == DATA_LAST) begin
          valid_out_nxt = 1'b0;
          data_out_nxt  = 1'b0;
          bit_cnt_nxt   = '0;
          ready_nxt     = 1'b1;
          state_nxt     = IDLE;
        end else begin
          // Rotate so the next bit to send is always one below the MSB.
          rshift_nxt   = {rshift[DATA_WIDTH-2:0], rshift[DATA_WIDTH-1]};
          data_out_nxt = rshift[DATA_WIDTH-2];
          bit_cnt_nxt  = bit_cnt + 1'b1;
        end
      end

      default: begin
        bit_cnt_nxt   = '0;
        ready_nxt     = 1'b1;
        valid_out_nxt = 1'b0;
        data_out_nxt  = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_slave_port.sv
module tb_bus_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset, s_address, s_data, s_valid, s_write_en;
  logic s_data_out, s_ready, s_valid_out;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_data(s_data),
    .s_valid(s_valid), .s_write_en(s_write_en), .s_data_out(s_data_out),
    .s_ready(s_ready), .s_valid_out(s_valid_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial write; abort_at >= 0 drops s_valid after that many data bits.
  // cyc counts edges from the first sampled bit until s_ready is seen high.
  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit hold, input int abort_at, output int cyc);
    cyc = 0;
    s_valid = 1'b1; s_write_en = 1'b1; s_address = a[AW-1]; s_data = 1'($urandom);
    tick(); cyc++;
    s_write_en = 1'b0;
    for (int i = AW-2; i >= 0; i--) begin
      s_address = a[i]; s_data = 1'($urandom);
      tick(); cyc++;
    end
    for (int j = DW-1; j >= 0; j--) begin
      if (DW-1-j == abort_at) begin
        s_valid = 1'b0;
        tick(); cyc++;
        return;
      end
      s_data = d[j]; s_address = 1'($urandom);
      tick(); cyc++;
    end
    if (!hold) s_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick(); cyc++;
      if (s_ready) break;
    end
    model[int'(a)] = d;
  endtask

  // Serial read; collects up to maxb read-data bits (bounded wait for s_valid_out).
  task automatic drive_read(input logic [AW-1:0] a, input int maxb,
                            output logic [DW-1:0] word, output int nv, output bit to);
    word = '0; nv = 0;
    s_valid = 1'b1; s_write_en = 1'b0; s_address = a[AW-1]; s_data = 1'($urandom);
    tick();
    s_write_en = 1'b1;
    for (int i = AW-2; i >= 0; i--) begin
      s_address = a[i]; s_data = 1'($urandom);
      tick();
    end
    for (int w = 0; w < 4 && !s_valid_out; w++) tick();
    to = !s_valid_out;
    for (int k = 0; k < maxb; k++) begin
      if (!s_valid_out) break;
      word = {word[DW-2:0], s_data_out};
      nv++;
      tick();
    end
    if (maxb == DW) s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_write_en = 1'b0; s_address = 1'b0; s_data = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    vectors++;
    if (s_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %b want 0", s_valid_out); end
    vectors++;
    if (s_data_out !== 1'b0) begin miscompares++; $display("FAIL reset_data_out: got %b want 0", s_data_out); end
  endtask

  task automatic test_write_read();
    int cyc, nv; bit to; logic [DW-1:0] w, e;
    drive_write(12'h003, 8'hA5, 1'b0, -1, cyc);
    vectors++;
    if (cyc !== AW+DW+1) begin miscompares++; $display("FAIL wr_span: got %0d want %0d", cyc, AW+DW+1); end
    exp_q.push_back(model[3]);
    drive_read(12'h003, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to) begin miscompares++; $display("FAIL rd_timeout: got timeout want s_valid_out"); end
    vectors++;
    if (w !== e) begin miscompares++; $display("FAIL rd_word_003: got %h want %h", w, e); end
    vectors++;
    if (nv !== DW) begin miscompares++; $display("FAIL rd_valid_len: got %0d want %0d", nv, DW); end
    vectors++;
    if ({s_valid_out, s_data_out, s_ready} !== 3'b001) begin
      miscompares++; $display("FAIL rd_end_state: got %b want 001", {s_valid_out, s_data_out, s_ready});
    end
  endtask

  task automatic test_boundary_addr();
    int cyc, nv; bit to; logic [DW-1:0] w, e;
    drive_write(12'hFFF, 8'h3C, 1'b0, -1, cyc);
    vectors++;
    if (cyc !== AW+DW+1) begin miscompares++; $display("FAIL wr_span_fff: got %0d want %0d", cyc, AW+DW+1); end
    drive_write(12'h000, 8'h11, 1'b0, -1, cyc);
    tick();
    exp_q.push_back(model['hFFF]);
    drive_read(12'hFFF, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL rd_fff: got %h (%0d bits, to=%0b) want %h", w, nv, to, e);
    end
    exp_q.push_back(model[0]);
    drive_read(12'h000, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL rd_000: got %h (%0d bits, to=%0b) want %h", w, nv, to, e);
    end
  endtask

  task automatic test_abort_write();
    int cyc, nv; bit to; logic [DW-1:0] w, e;
    drive_write(12'h010, 8'h5A, 1'b0, -1, cyc);
    drive_write(12'h010, 8'h77, 1'b0, 4, cyc);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", s_ready); end
    tick();
    exp_q.push_back(model['h010]);
    drive_read(12'h010, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL abort_keeps_old: got %h (%0d bits) want %h", w, nv, e);
    end
  endtask

  task automatic test_reset_mid_read();
    int nv; bit to; logic [DW-1:0] w, e;
    e = model[3];
    drive_read(12'h003, 3, w, nv, to);
    vectors++;
    if (to || nv !== 3 || w[2:0] !== e[DW-1:DW-3]) begin
      miscompares++; $display("FAIL partial_read: got %b (%0d bits) want %b", w[2:0], nv, e[DW-1:DW-3]);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (s_valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid_out: got %b want 0", s_valid_out); end
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", s_ready); end
    s_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(model[3]);
    drive_read(12'h003, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL rd_after_rst: got %h (%0d bits) want %h", w, nv, e);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, nv; bit to; logic [DW-1:0] w, e;
    drive_write(12'h123, 8'hC3, 1'b1, -1, cyc1);
    drive_write(12'h456, 8'h96, 1'b0, -1, cyc2);
    vectors++;
    if (cyc1 !== AW+DW+1 || cyc2 !== AW+DW+1) begin
      miscompares++; $display("FAIL b2b_span: got %0d/%0d want %0d", cyc1, cyc2, AW+DW+1);
    end
    tick();
    exp_q.push_back(model['h123]);
    drive_read(12'h123, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL b2b_rd_123: got %h (%0d bits) want %h", w, nv, e);
    end
    exp_q.push_back(model['h456]);
    drive_read(12'h456, DW, w, nv, to);
    e = exp_q.pop_front();
    vectors++;
    if (to || w !== e || nv !== DW) begin
      miscompares++; $display("FAIL b2b_rd_456: got %h (%0d bits) want %h", w, nv, e);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundary_addr();
    test_abort_write();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
